// File: rtl/pipelined_addsub_gen.sv
// Pipelined ripple-carry adder/subtractor: one WIDTH/STAGES-bit carry chunk is resolved per
// stage, operands are skewed through the pipe, and a valid/ready handshake sits on both ends.
module pipelined_addsub_gen #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf
);

   localparam int C = WIDTH / STAGES;
   localparam int L = STAGES - 1;

   // Bit-serial ripple across one chunk; returns {carry_out, chunk_sum}.
   function automatic logic [C:0] chunk_add(input logic [C-1:0] x, input logic [C-1:0] y,
                                            input logic cin);
      logic [C:0] r;
      logic       c;
      r = '0;
      c = cin;
      for (int i = 0; i < C; i++) begin
         r[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      r[C] = c;
      return r;
   endfunction

   logic             vld_p [STAGES];
   logic [WIDTH-1:0] a_p   [STAGES];
   logic [WIDTH-1:0] b_p   [STAGES];
   logic [WIDTH-1:0] s_p   [STAGES];
   logic             cy_p  [STAGES];
   logic             ovf_p;

   logic [WIDTH-1:0] op_a  [STAGES];
   logic [WIDTH-1:0] op_b  [STAGES];
   logic [WIDTH-1:0] op_s  [STAGES];
   logic             op_c  [STAGES];
   logic             op_v  [STAGES];
   logic [C:0]       res   [STAGES];

   logic advance;
   logic ovf_nxt;

   assign advance   = out_ready || !out_valid;
   assign in_ready  = advance;
   assign out_valid = vld_p[L];
   assign sum       = s_p[L];
   assign co        = cy_p[L];
   assign ovf       = ovf_p;

   genvar k;
   for (k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         // B and the carry are inverted once at entry so every stage just adds.
         assign op_a[k] = a;
         assign op_b[k] = sub ? ~b : b;
         assign op_c[k] = sub ? ~ci : ci;
         assign op_s[k] = '0;
         assign op_v[k] = in_valid;
      end else begin : g_next
         assign op_a[k] = a_p[k-1];
         assign op_b[k] = b_p[k-1];
         assign op_c[k] = cy_p[k-1];
         assign op_s[k] = s_p[k-1];
         assign op_v[k] = vld_p[k-1];
      end

      assign res[k] = chunk_add(op_a[k][k*C +: C], op_b[k][k*C +: C], op_c[k]);

      // Stage k boundary: the whole pipe moves together or holds together.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_p[k] <= 1'b0;
            a_p[k]   <= '0;
            b_p[k]   <= '0;
            s_p[k]   <= '0;
            cy_p[k]  <= 1'b0;
         end else if (advance) begin
            vld_p[k] <= op_v[k];
            if (op_v[k]) begin
               a_p[k]              <= op_a[k];
               b_p[k]              <= op_b[k];
               s_p[k]              <= op_s[k];
               s_p[k][k*C +: C]    <= res[k][C-1:0];
               cy_p[k]             <= res[k][C];
            end
         end
      end
   end

   assign ovf_nxt = (op_a[L][WIDTH-1] == op_b[L][WIDTH-1]) &&
                    (res[L][C-1] != op_a[L][WIDTH-1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_p <= 1'b0;
      end else if (advance && op_v[L]) begin
         ovf_p <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_pipelined_addsub_gen.sv
// Bench for pipelined_addsub_gen (WIDTH=16, STAGES=4): directed vector table, streaming,
// backpressure, random handshake traffic and asynchronous reset mid-stream.
module tb_pipelined_addsub_gen;

   localparam int WIDTH  = 16;
   localparam int STAGES = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             co;
   logic             ovf;

   int checks   = 0;
   int failures = 0;

   logic [17:0] exp_q[$];

   pipelined_addsub_gen #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .ci       (ci),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .co       (co),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] va;
      logic [15:0] vb;
      logic        vci;
      logic        vsub;
      logic [15:0] es;
      logic        eco;
      logic        eov;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: {ovf, co, sum} from plain integer arithmetic.
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input logic c, input logic s);
      logic [15:0] yb;
      logic        cb;
      logic [16:0] f;
      yb = s ? ~y : y;
      cb = s ? ~c : c;
      f  = {1'b0, x} + {1'b0, yb} + {16'b0, cb};
      return {(x[15] == yb[15]) && (f[15] != x[15]), f[16], f[15:0]};
   endfunction

   // One isolated beat; checks latency and result.
   task automatic apply_vec(input vec_t v);
      int n;
      @(negedge clk);
      a = v.va; b = v.vb; ci = v.vci; sub = v.vsub; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      check({v.name, "_latency"}, n, STAGES - 1);
      check({v.name, "_sum"}, {16'b0, sum}, {16'b0, v.es});
      check({v.name, "_co"}, {31'b0, co}, {31'b0, v.eco});
      check({v.name, "_ovf"}, {31'b0, ovf}, {31'b0, v.eov});
   endtask

   // mode 0: a=i, b=3i, ci=i[0] at full input rate; mode 1: random operands and handshakes.
   task automatic run_stream(input string name, input int nbeats, input int mode,
                             input int stall_start, input int stall_len, input bit check_rate);
      int sent = 0, got = 0, cyc = 0;
      int first_acc = -1, first_cons = -1, last_cons = -1;
      int budget;
      logic [17:0] snap = '0;
      logic [17:0] e;
      bit stall;
      budget = nbeats * 8 + 50;
      exp_q.delete();
      while (got < nbeats && cyc < budget) begin
         @(negedge clk);
         stall = (cyc >= stall_start) && (cyc < stall_start + stall_len);
         if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
         else           out_ready = !stall;
         if (sent < nbeats) begin
            if (mode == 1) begin
               in_valid = ($urandom_range(0, 3) != 0);
               a = 16'($urandom); b = 16'($urandom);
               ci = 1'($urandom); sub = 1'($urandom);
            end else begin
               in_valid = 1'b1;
               a = 16'(sent); b = 16'(3 * sent); ci = 1'(sent); sub = 1'b0;
            end
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (stall) begin
            check({name, "_stall_in_ready"}, {31'b0, in_ready}, 32'd0);
            if (cyc == stall_start) snap = {ovf, co, sum};
            else check({name, "_stall_hold"}, {14'b0, ovf, co, sum}, {14'b0, snap});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check({name, "_unexpected_result"}, {14'b0, ovf, co, sum}, 32'hDEAD);
            end else begin
               e = exp_q.pop_front();
               check({name, "_result"}, {14'b0, ovf, co, sum}, {14'b0, e});
            end
            if (first_cons < 0) first_cons = cyc;
            last_cons = cyc;
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, ci, sub));
            if (first_acc < 0) first_acc = cyc;
            sent++;
         end
         cyc++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      check({name, "_beats_received"}, got, nbeats);
      check({name, "_queue_empty"}, exp_q.size(), 0);
      if (check_rate) begin
         check({name, "_first_latency"}, first_cons - first_acc, STAGES);
         check({name, "_throughput"}, last_cons - first_cons, nbeats - 1);
      end
   endtask

   initial begin
      int i, n, stale;
      vecs[0] = '{"add_ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[1] = '{"add_ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[2] = '{"sub_neg",      16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[3] = '{"sub_ovf",      16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[4] = '{"add_ci",       16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
      vecs[5] = '{"sub_borrow",   16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
      vecs[6] = '{"add_neg_ovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[7] = '{"sub_zero",     16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[8] = '{"add_ci_chunk", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; ci = 1'b0; sub = 1'b0;
      #12;
      check("reset_out_valid", {31'b0, out_valid}, 32'd0);
      check("reset_outputs", {14'b0, ovf, co, sum}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("idle_in_ready", {31'b0, in_ready}, 32'd1);

      for (int v = 0; v < 9; v++) apply_vec(vecs[v]);

      run_stream("stream", 32, 0, 1 << 30, 0, 1'b1);
      run_stream("backpressure", 20, 0, 8, 5, 1'b0);
      run_stream("random", 1000, 1, 1 << 30, 0, 1'b0);

      // Asynchronous reset while one result is presented and three beats are in flight.
      i = 1;
      n = 0;
      out_ready = 1'b1;
      do begin
         @(negedge clk);
         a = 16'(16'h1111 * i); b = 16'h0101; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
         #1;
         i++;
         n++;
      end while (!out_valid && n < 12);
      check("pre_reset_out_valid", {31'b0, out_valid}, 32'd1);
      check("pre_reset_sum", {16'b0, sum}, 32'h1212);
      #2;
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      check("async_reset_out_valid", {31'b0, out_valid}, 32'd0);
      check("async_reset_outputs", {14'b0, ovf, co, sum}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      check("post_reset_no_stale", stale, 0);
      apply_vec('{"post_reset_beat", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipelined_addsub_gen.md
Name: pipelined_addsub_gen

Overview:
Parametrised, pipelined ripple-carry adder/subtractor and the generalised successor to the team's generate-loop gate-level adder. The operand width is split into STAGES equal chunks, with one chunk's carry chain resolved per pipeline stage and operands skewed. A valid/ready handshake on both sides lets the block sit directly in streaming datapaths, and it adds subtract mode, signed overflow, and backpressure.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages, which is also the latency in cycles; 1 ≤ STAGES ≤ WIDTH.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  block accepts a beat this cycle.
a  input  WIDTH  operand A (unsigned or two's complement).
b  input  WIDTH  operand B.
ci  input  1  carry-in when sub=0; borrow-in when sub=1.
sub  input  1  0 = add, 1 = subtract.
out_valid  output  1  result beat valid.
out_ready  input  1  downstream accepts the result.
sum  output  WIDTH  result.
co  output  1  carry-out when adding; NOT borrow-out when subtracting.
ovf  output  1  signed two's-complement overflow.

Behaviour:
- Arithmetic: C = WIDTH/STAGES.
  - sub=0: {co,sum} = a + b + ci.
  - sub=1: {co,sum} = a + ~b + ~ci, i.e. a − b − ci.
  - ovf = (opA[W-1] == opB'[W-1]) && (sum[W-1] != opA[W-1]), where opB' is the inverted B when subtracting.
- Pipeline: stage k (0..STAGES-1) computes sum bits [kC+C-1:kC] from the registered carry of stage k-1; stage 0 uses the effective carry-in.
  - Unprocessed upper operand chunks, already B-inverted, travel with the beat.
  - Completed lower sum chunks also travel with the beat.
  - Each stage has its own valid bit.
- Latency: a beat accepted at edge N appears on the outputs after edge N+STAGES-1. For STAGES=1, the output register is loaded at the accept edge. co, ovf and sum are registered outputs.
- Stall: advance = out_ready || !out_valid.
  - in_ready = advance.
  - When advance=0, every stage register holds its value, including valid bits.
  - Bubbles are not collapsed.
- Acceptance: a beat is transferred when in_valid && in_ready. If in_valid=0 while advancing, a bubble with valid=0 is inserted.
- Output: a result is consumed when out_valid && out_ready. sum/co/ovf are held stable while out_valid=1 and out_ready=0.
- Data registers of invalid stages may hold any value, but sum/co/ovf must not change while out_valid=0 and the pipe is stalled.
- Reset (asynchronous, any time including mid-stream): all stage valids clear, so out_valid=0. sum=0, co=0, ovf=0. in_ready=1 while rst is deasserted and the pipe is empty. Beats in flight are discarded.
- Simultaneous accept and consume in the same cycle sustain full throughput of one beat per cycle.
- Carry wrap-around: co from the top chunk is the true carry-out. No saturation is applied.
- The implementation uses a generate loop over stages. The carry is rippled within a chunk; no carry-lookahead is required.

Test Plan:
All cases use WIDTH=16, STAGES=4, out_ready=1 unless stated otherwise.
1. Add with carry ripple: a=0xFFFF, b=0x0001, ci=0, sub=0 → after 4 cycles sum=0x0000, co=1, ovf=0; the carry must cross every stage.
2. Signed overflow: a=0x7FFF, b=0x0001, sub=0 → sum=0x8000, co=0, ovf=1.
3. Subtract:
   - a=0x0005, b=0x0007, ci=0, sub=1 → sum=0xFFFE, co=0, ovf=0.
   - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, co=1, ovf=1.
4. Streaming: back-to-back beats (a=i, b=3i, ci=i[0]) for i=0..31 → one result per cycle from cycle 4, in order, all matching a reference model.
5. Backpressure:
   - Drop out_ready for 5 cycles mid-stream → in_ready=0 and sum/co/ovf held constant during the stall.
   - Release → no beat lost or duplicated; with random in_valid/out_ready over 1000 beats, the scoreboard matches.
6. Reset mid-stream: assert rst asynchronously (between edges) while 3 beats are in flight → out_valid=0, sum=0, co=0, ovf=0 immediately. After release, the first new beat emerges exactly 4 cycles after acceptance and no stale results appear.
